gfx256_rd_arbiter: RTL and testbench
====================================

# gfx256_rd_arbiter

Shares the single wishbone-master read port (`wbm_read`) between several 256-bit line requesters: z-buffer reads from clip, texture reads from fragment, and destination reads from blender. Arbitration is round-robin and one transaction is outstanding at a time. An optional one-line read buffer answers repeat reads of the same 32-byte line without a bus cycle. The block sits between the pipeline stages and the wishbone master reader, and presents each requester the same hold-until-ack request protocol that clip's `z_request_o` uses.

## Interface
- `NREQ`, default 3: number of requesters. Index 0 is z-buffer, 1 is texture, 2 is blender.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in NREQ: per-requester read request, held high until the matching `ack_o` bit.
- `addr_i` in NREQ×27: per-requester line address [31:5], stable while `req_i` is high.
- `sel_i` in NREQ×32: per-requester byte selects.
- `ack_o` out NREQ: one-cycle acknowledge, one-hot.
- `data_o` out 256: read line, valid while any `ack_o` bit is high.
- `mem_request_o` out 1: read request to the wbm reader.
- `mem_addr_o` out 27: address [31:5].
- `mem_sel_o` out 32: byte selects.
- `mem_ack_i` in 1: reader acknowledge. Its data is valid in the same cycle.
- `mem_data_i` in 256: reader data.
- `wbm_busy_i` in 1: the reader is busy with another master.
- `snoop_valid_i` in 1: a pixel write is happening this cycle.
- `snoop_addr_i` in 27: line address of that write.
- `flush_i` in 1: invalidate the line buffer.

## Operation
- States:
  - IDLE: pick a winner and register the grant, then go to HITCHK.
  - HITCHK: on a line-buffer hit go to RESP; otherwise go to ISSUE.
  - ISSUE: assert `mem_request_o` once `wbm_busy_i` is low. The request stays asserted until ack, independent of later busy.
  - WAIT: on `mem_ack_i`, capture data, drop `mem_request_o`, go to RESP.
  - RESP: pulse `ack_o[grant]` with `data_o`, go to IDLE.
- Round-robin:
  - The pointer holds the last granted index; the search starts at pointer+1 and wraps at NREQ-1 → 0.
  - Reset pointer = NREQ-1, so requester 0 wins first.
  - The pointer updates only in RESP.
- `mem_addr_o` and `mem_sel_o` are registered from the winner in IDLE and held constant until the ack.
- The grant is held; a requester dropping `req_i` mid-transaction is illegal and is not checked.
- Requesters drop `req_i` in the cycle after ack. IDLE therefore never re-grants the same requester on a stale request.
- With no requests, the block stays in IDLE and all outputs stay zero.

## Timing
- Reset values: `ack_o`=0, `data_o`=0, `mem_request_o`=0, `mem_addr_o`=0, `mem_sel_o`=0, state=IDLE, buffer valid=0.
- Asynchronous reset mid-transaction drops `mem_request_o` immediately. The wbm reader is reset by the same signal, and no late ack is honoured.
- Hit latency: `req_i` high at cycle N (IDLE) → `ack_o` at N+2.
- Miss latency: `mem_request_o` rises at N+2 (if not busy) → `mem_ack_i` at M → `ack_o` at M+1.
- Back-to-back: the next grant is decided in the cycle after RESP, so there are 3 dead cycles minimum between misses.
- Simultaneous events:
  - Snoop hitting the tag in the same cycle as a fill: the buffer ends invalid, but the fetched data is still returned.
  - `flush_i` during WAIT: same rule as a snoop hit.

## Configuration
- Macro `GFX256_RDARB_LINEBUF_EN` defined:
  - One 256-bit data register plus a 27-bit tag and a valid bit.
  - A hit requires valid, tag==addr, and no snoop/flush hit in that cycle.
  - Every fill loads the buffer.
- Macro undefined:
  - No buffer storage.
  - HITCHK always goes to ISSUE; latency and bus traffic are the miss path only.
  - `snoop_*` and `flush_i` are ignored.

## Structure
- In `gfx256_pkg`:
  - `typedef enum logic [2:0] rdarb_state_e {IDLE, HITCHK, ISSUE, WAIT, RESP}`.
  - Localparams `RDARB_REQ_Z`=0, `RDARB_REQ_TEX`=1, `RDARB_REQ_BLEND`=2.
- Sub-module `gfx256_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, encoded index, and `any`.

## Test plan
- Single miss:
  - Stimulus: `req_i`=001, addr=0x0001000, reader acks 4 cycles after request with data 0xA5…A5.
  - Response: `ack_o`=001 one cycle later, `data_o`=0xA5…A5, `mem_request_o` low the next cycle.
- Fairness:
  - Stimulus: `req_i`=111 held continuously and each requester re-requests after its ack.
  - Response: grant order is 0, 1, 2, 0, 1, 2; no requester is starved.
- Busy:
  - Stimulus: `wbm_busy_i`=1 for 10 cycles during ISSUE.
  - Response: `mem_request_o` stays 0 until busy falls, then rises the next cycle.
- Buffer hit (macro on):
  - Stimulus: two reads of 0x0002000.
  - Response: the second read acks at N+2 with no `mem_request_o`.
  - Repeat with a snoop write to 0x0002000 between the reads: the second read misses.
- Macro off:
  - Stimulus: the same two reads of 0x0002000.
  - Response: two bus transactions.
- Reset mid-WAIT:
  - Stimulus: `rst_ni` low during WAIT.
  - Response: `mem_request_o`=0 immediately, state=IDLE, pointer=NREQ-1, buffer invalid.

Source files
------------

// File: rtl/gfx256_pkg.sv
// gfx256_pkg: shared state encoding and requester indices for the gfx256 read arbiter
package gfx256_pkg;
    typedef enum logic [2:0] {IDLE, HITCHK, ISSUE, WAIT, RESP} rdarb_state_e;
    localparam int RDARB_REQ_Z     = 0;
    localparam int RDARB_REQ_TEX   = 1;
    localparam int RDARB_REQ_BLEND = 2;
endpackage

// File: rtl/gfx256_rr_pick.sv
// gfx256_rr_pick: combinational round-robin picker, search starts just after the last grant
module gfx256_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);
    logic [IW-1:0] j;
    // Walk from farthest to nearest candidate so the nearest one after ptr wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IW'((int'(ptr_i) + k) % NREQ);
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = j;
                any_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gfx256_rd_arbiter.sv
// gfx256_rd_arbiter: round-robin share of the wbm read port between 256-bit line requesters.
// Define GFX256_RDARB_LINEBUF_EN to add a one-line read buffer invalidated by snoop/flush.
module gfx256_rd_arbiter
    import gfx256_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0][26:0] addr_i,
    input  logic [NREQ-1:0][31:0] sel_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [255:0]          data_o,
    output logic                  mem_request_o,
    output logic [26:0]           mem_addr_o,
    output logic [31:0]           mem_sel_o,
    input  logic                  mem_ack_i,
    input  logic [255:0]          mem_data_i,
    input  logic                  wbm_busy_i,
    input  logic                  snoop_valid_i,
    input  logic [26:0]           snoop_addr_i,
    input  logic                  flush_i
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

    rdarb_state_e    state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gidx_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic [255:0]    data_q;
    logic            mreq_q;
    logic [26:0]     maddr_q;
    logic [31:0]     msel_q;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            hit;
    logic            fill;
    logic [255:0]    lb_data;

    gfx256_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign fill = (state_q == ISSUE || state_q == WAIT) && mreq_q && mem_ack_i;

`ifdef GFX256_RDARB_LINEBUF_EN
    logic         lb_valid_q;
    logic         lb_valid_d;
    logic [26:0]  lb_tag_q;
    logic [255:0] lb_data_q;
    logic         kill_req;
    logic         kill_tag;

    assign kill_req = flush_i || (snoop_valid_i && snoop_addr_i == maddr_q);
    assign kill_tag = flush_i || (snoop_valid_i && snoop_addr_i == lb_tag_q);
    assign hit      = lb_valid_q && lb_tag_q == maddr_q && !kill_req;
    assign lb_data  = lb_data_q;

    // A fill that collides with a write to its own line is returned but not kept
    always_comb lb_valid_d = fill ? !kill_req : lb_valid_q && !kill_tag;

    // Line buffer storage, loaded on every bus fill
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
        end else begin
            lb_valid_q <= lb_valid_d;
            if (fill) begin
                lb_tag_q  <= maddr_q;
                lb_data_q <= mem_data_i;
            end
        end
    end
`else
    logic unused_snoop;

    assign unused_snoop = ^{snoop_valid_i, snoop_addr_i, flush_i};
    assign hit          = 1'b0;
    assign lb_data      = '0;
`endif

    // Arbitration, bus handshake and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            gidx_q  <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            mreq_q  <= 1'b0;
            maddr_q <= '0;
            msel_q  <= '0;
        end else begin
            ack_q  <= '0;
            data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q   <= pick_gnt;
                        gidx_q  <= pick_idx;
                        maddr_q <= addr_i[pick_idx];
                        msel_q  <= sel_i[pick_idx];
                        state_q <= HITCHK;
                    end
                end
                HITCHK: begin
                    if (hit) begin
                        ack_q   <= gnt_q;
                        data_q  <= lb_data;
                        state_q <= RESP;
                    end else begin
                        mreq_q  <= !wbm_busy_i;
                        state_q <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (fill) begin
                        ack_q   <= gnt_q;
                        data_q  <= mem_data_i;
                        mreq_q  <= 1'b0;
                        state_q <= RESP;
                    end else if (mreq_q) begin
                        state_q <= WAIT;
                    end else begin
                        mreq_q <= !wbm_busy_i;
                    end
                end
                RESP: begin
                    ptr_q   <= gidx_q;
                    maddr_q <= '0;
                    msel_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o         = ack_q;
    assign data_o        = data_q;
    assign mem_request_o = mreq_q;
    assign mem_addr_o    = maddr_q;
    assign mem_sel_o     = msel_q;
endmodule

// File: tb/tb_gfx256_rd_arbiter.sv
// tb_gfx256_rd_arbiter: directed and randomized checks against a transaction-level model
`timescale 1ns/1ps
module tb_gfx256_rd_arbiter;
    localparam int NREQ = 3;
`ifdef GFX256_RDARB_LINEBUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0][26:0] addr_i;
    logic [NREQ-1:0][31:0] sel_i;
    logic [NREQ-1:0]       ack_o;
    logic [255:0]          data_o;
    logic                  mem_request_o;
    logic [26:0]           mem_addr_o;
    logic [31:0]           mem_sel_o;
    logic                  mem_ack_i;
    logic [255:0]          mem_data_i;
    logic                  wbm_busy_i;
    logic                  snoop_valid_i;
    logic [26:0]           snoop_addr_i;
    logic                  flush_i;

    gfx256_rd_arbiter #(.NREQ(NREQ)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .sel_i         (sel_i),
        .ack_o         (ack_o),
        .data_o        (data_o),
        .mem_request_o (mem_request_o),
        .mem_addr_o    (mem_addr_o),
        .mem_sel_o     (mem_sel_o),
        .mem_ack_i     (mem_ack_i),
        .mem_data_i    (mem_data_i),
        .wbm_busy_i    (wbm_busy_i),
        .snoop_valid_i (snoop_valid_i),
        .snoop_addr_i  (snoop_addr_i),
        .flush_i       (flush_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // model state: last grant, line buffer contents, current transaction timing
    int cyc, ptr, win, dec, exp_ack, rcyc, bd, bus_dly, nbus;
    int auto_pct, busy_pct, snoop_pct, flush_pct;
    bit bvalid, free_m, issuing, rq, prev_mreq, fill_flush, use_fix, busy_force, snoop_now;
    logic [26:0]  btag, t_addr, snoop_now_addr;
    logic [31:0]  t_sel;
    logic [255:0] bdata, exp_data, fix_data;
    int           cool [NREQ];
    bit           want [NREQ];
    logic [26:0]  want_addr [NREQ];
    int           order [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] rnd_addr();
        case ($urandom_range(3))
            0: return 27'h0002000;
            1: return 27'h0001000;
            2: return 27'h0002001;
            default: return 27'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        ptr = NREQ - 1; win = 0; dec = -10; exp_ack = -10; rcyc = -1; bd = 0;
        bvalid = 0; free_m = 1; issuing = 0; rq = 0; prev_mreq = 0; snoop_now = 0;
        req_i = '0; addr_i = '0; sel_i = '0; mem_ack_i = 0; mem_data_i = '0;
        wbm_busy_i = 0; snoop_valid_i = 0; snoop_addr_i = '0; flush_i = 0;
        for (int i = 0; i < NREQ; i++) begin cool[i] = 0; want[i] = 0; end
    endtask

    // one clock: check outputs, then drive the next inputs and advance the model
    task automatic step();
        bit seen_ack, ack_now, nrq;
        @(negedge clk_i);
        cyc++;
        seen_ack = (cyc == exp_ack);
        chk("ack_o", 256'(ack_o), seen_ack ? (256'(1) << win) : 256'(0));
        if (seen_ack) chk("data_o", data_o, exp_data);
        chk("mem_request_o", 256'(mem_request_o), 256'(rq));
        if (rq) begin
            chk("mem_addr_o", 256'(mem_addr_o), 256'(t_addr));
            chk("mem_sel_o", 256'(mem_sel_o), 256'(t_sel));
        end
        if (mem_request_o && !prev_mreq) nbus++;
        prev_mreq = mem_request_o;
        nrq = rq;
        if (seen_ack) begin
            req_i[win] = 1'b0;
            cool[win] = 2;
            ptr = win;
            order.push_back(win);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (cool[i] == 0 && !req_i[i] && (want[i] || $urandom_range(99) < auto_pct)) begin
                req_i[i] = 1'b1;
                addr_i[i] = want[i] ? want_addr[i] : rnd_addr();
                sel_i[i] = $urandom;
                want[i] = 0;
            end
            if (cool[i] > 0) cool[i]--;
        end
        if (rq && rcyc < 0) begin
            rcyc = cyc;
            bd = bus_dly >= 0 ? bus_dly : int'($urandom_range(4));
        end
        ack_now = rq && rcyc >= 0 && cyc == rcyc + bd;
        snoop_valid_i = snoop_now || ($urandom_range(99) < snoop_pct);
        snoop_addr_i = snoop_now ? snoop_now_addr : rnd_addr();
        snoop_now = 0;
        flush_i = (fill_flush && ack_now) || ($urandom_range(99) < flush_pct);
        wbm_busy_i = busy_force || ($urandom_range(99) < busy_pct);
        if (cyc == dec + 1) begin
            if (LB && bvalid && btag == t_addr && !flush_i && !(snoop_valid_i && snoop_addr_i == t_addr)) begin
                exp_ack = cyc + 1;
                exp_data = bdata;
            end else issuing = 1;
        end
        mem_ack_i = ack_now;
        mem_data_i = '0;
        if (ack_now) begin
            mem_data_i = use_fix ? fix_data : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp_data = mem_data_i;
            exp_ack = cyc + 1;
            nrq = 0;
            rcyc = -1;
            btag = t_addr;
            bdata = mem_data_i;
            bvalid = LB && !flush_i && !(snoop_valid_i && snoop_addr_i == t_addr);
        end else if (flush_i || (snoop_valid_i && snoop_addr_i == btag)) bvalid = 0;
        if (issuing && !wbm_busy_i) begin
            nrq = 1;
            issuing = 0;
        end
        if (free_m && req_i != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (req_i[(ptr + k) % NREQ]) begin
                    win = (ptr + k) % NREQ;
                    break;
                end
            end
            free_m = 0;
            dec = cyc;
            t_addr = addr_i[win];
            t_sel = sel_i[win];
        end
        if (seen_ack) free_m = 1;
        rq = nrq;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (!(free_m && req_i == '0) && n < lim) begin
            step();
            n++;
        end
        chk("drain_timeout", 256'(free_m && req_i == '0), 256'(1));
    endtask

    task automatic read1(input int i, input logic [26:0] a);
        want[i] = 1;
        want_addr[i] = a;
        step();
        drain(100);
    endtask

    task automatic pair(input logic [26:0] a, input bit snoop_mid, input bit fof, input int exp_n, input string tag);
        int n0;
        snoop_now = 1;
        snoop_now_addr = a;
        step();
        n0 = nbus;
        fill_flush = fof;
        read1(1, a);
        fill_flush = 0;
        if (snoop_mid) begin
            snoop_now = 1;
            snoop_now_addr = a;
            step();
        end
        read1(2, a);
        chk(tag, 256'(nbus - n0), 256'(exp_n));
    endtask

    initial begin
        int n0;
        rst_ni = 0;
        cyc = 0; nbus = 0; bus_dly = -1;
        auto_pct = 0; busy_pct = 0; snoop_pct = 0; flush_pct = 0;
        fill_flush = 0; use_fix = 0; busy_force = 0; fix_data = {32{8'hA5}};
        btag = '0; bdata = '0; t_addr = '0; t_sel = '0; exp_data = '0; snoop_now_addr = '0;
        model_reset();
        repeat (3) step();
        chk("rst_ack_o", 256'(ack_o), 256'(0));
        chk("rst_data_o", data_o, 256'(0));
        chk("rst_mem_request_o", 256'(mem_request_o), 256'(0));
        chk("rst_mem_addr_o", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_sel_o", 256'(mem_sel_o), 256'(0));
        rst_ni = 1;
        repeat (4) step();

        // fairness with every requester re-requesting right after its ack
        order.delete();
        auto_pct = 100;
        for (int n = 0; n < 300 && order.size() < 6; n++) step();
        auto_pct = 0;
        drain(200);
        chk("fair_count", 256'(order.size() >= 6), 256'(1));
        for (int i = 0; i < 6 && i < order.size(); i++) chk("fair_order", 256'(order[i]), 256'(i % 3));

        // single miss with a 4-cycle reader latency and a fixed data pattern
        use_fix = 1;
        bus_dly = 4;
        order.delete();
        read1(0, 27'h0001000);
        chk("miss_grant", 256'(order.size() == 1 && order[0] == 0), 256'(1));
        use_fix = 0;

        // reader busy for 10 cycles around the issue
        n0 = nbus;
        bus_dly = -1;
        busy_force = 1;
        want[2] = 1;
        want_addr[2] = 27'h0003000;
        repeat (10) step();
        busy_force = 0;
        drain(100);
        chk("busy_bus_count", 256'(nbus - n0), 256'(1));

        // repeat reads of one line: plain, snooped in between, flushed on fill
        pair(27'h0002000, 0, 0, LB ? 1 : 2, "repeat_bus_count");
        pair(27'h0002000, 1, 0, 2, "snoop_bus_count");
        pair(27'h0004000, 0, 1, 2, "fill_flush_bus_count");

        // randomized traffic with busy, snoops and flushes
        auto_pct = 25; busy_pct = 20; snoop_pct = 10; flush_pct = 3;
        repeat (400) step();
        auto_pct = 0; busy_pct = 0; snoop_pct = 0; flush_pct = 0;
        drain(200);

        // reset while waiting for the reader
        bus_dly = 2;
        read1(1, 27'h0005000);
        bus_dly = 30;
        want[1] = 1;
        want_addr[1] = 27'h0006000;
        repeat (6) step();
        #1 rst_ni = 0;
        #1;
        chk("rstw_mem_request_o", 256'(mem_request_o), 256'(0));
        chk("rstw_ack_o", 256'(ack_o), 256'(0));
        chk("rstw_mem_addr_o", 256'(mem_addr_o), 256'(0));
        model_reset();
        repeat (2) step();
        rst_ni = 1;
        bus_dly = 2;
        order.delete();
        n0 = nbus;
        want[0] = 1; want_addr[0] = 27'h0005000;
        want[1] = 1; want_addr[1] = 27'h0007000;
        want[2] = 1; want_addr[2] = 27'h0008000;
        step();
        drain(200);
        chk("rstw_first_grant", 256'(order.size() > 0 && order[0] == 0), 256'(1));
        chk("rstw_buffer_cleared", 256'(nbus - n0), 256'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
